// File: rtl/maze_tile_arbiter.sv
// Maze tile map owner: round-robin requester arbitration, default-maze loader, drawer read port.
// Optional build macro MAZE_ARB_PRIO0_EN gives requester 0 fixed priority over the others.
module maze_tile_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ROWS    = 13,
  parameter int COLS    = 19
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   init_req,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     we,
  input  logic [NUM_REQ*4-1:0]   req_row,
  input  logic [NUM_REQ*5-1:0]   req_col,
  input  logic [NUM_REQ*2-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rvalid,
  output logic [1:0]             rdata,
  output logic [2:0]             rdata_id,
  output logic                   busy,
  input  logic [3:0]             rd_row,
  input  logic [4:0]             rd_col,
  output logic [1:0]             rd_code
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

`ifdef MAZE_ARB_PRIO0_EN
  localparam logic [PTR_W-1:0] PTR_BASE = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] PTR_BASE = '0;
`endif

  logic [0:0]         state_q, state_d;
  logic [3:0]         init_row_q, init_row_d;
  logic [4:0]         init_col_q, init_col_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rdata_q, rdata_d;
  logic [2:0]         rdata_id_q, rdata_id_d;
  logic               busy_q, busy_d;
  logic [1:0]         rd_code_q, rd_code_d;

  logic [1:0]         map_q [ROWS][COLS];

  logic               mem_we;
  logic [3:0]         mem_row;
  logic [4:0]         mem_col;
  logic [1:0]         mem_wdata;

  logic [NUM_REQ-1:0] req_elig;
  logic               found;
  logic               rr_adv;
  logic [2:0]         win_idx;
  logic               sel_we;
  logic [3:0]         sel_row;
  logic [4:0]         sel_col;
  logic [1:0]         sel_wdata;
  logic               sel_in_range;
  logic [1:0]         sel_cur;
  logic               rd_in_range;

  // Two-pass search: first eligible index at/after the pointer, else the lowest one (wrap).
  always_comb begin
    req_elig = req;
`ifdef MAZE_ARB_PRIO0_EN
    req_elig[0] = 1'b0;
`endif
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_elig[i] && (i >= int'(rr_ptr_q))) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_elig[i]) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    rr_adv = found;
`ifdef MAZE_ARB_PRIO0_EN
    if (req[0]) begin
      found   = 1'b1;
      win_idx = 3'd0;
      rr_adv  = 1'b0;
    end
`endif
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_row   = '0;
    sel_col   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_we    = we[i];
        sel_row   = req_row[4*i +: 4];
        sel_col   = req_col[5*i +: 5];
        sel_wdata = req_wdata[2*i +: 2];
      end
    end
    sel_in_range = (sel_row < 4'(ROWS)) && (sel_col < 5'(COLS));
    // Off-board cells look like walls so movement checks stop at the edge.
    sel_cur      = sel_in_range ? map_q[sel_row][sel_col] : 2'd1;
    rd_in_range  = (rd_row < 4'(ROWS)) && (rd_col < 5'(COLS));
    rd_code_d    = rd_in_range ? map_q[rd_row][rd_col] : 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    init_col_d = init_col_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    rdata_id_d = rdata_id_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_row    = init_row_q;
    mem_col    = init_col_q;
    mem_wdata  = {1'b0, init_row_q[0] & init_col_q[0]};

    case (state_q)
      ST_INIT: begin
        if (init_req) begin
          init_row_d = '0;
          init_col_d = '0;
          busy_d     = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (init_col_q == 5'(COLS - 1)) begin
            init_col_d = '0;
            if (init_row_q == 4'(ROWS - 1)) begin
              init_row_d = '0;
              state_d    = ST_IDLE;
              busy_d     = 1'b0;
            end else begin
              init_row_d = init_row_q + 4'd1;
            end
          end else begin
            init_col_d = init_col_q + 5'd1;
          end
        end
      end

      ST_IDLE: begin
        if (init_req) begin
          state_d    = ST_INIT;
          init_row_d = '0;
          init_col_d = '0;
          busy_d     = 1'b1;
        end else if (found) begin
          gnt_d[win_idx] = 1'b1;
          if (rr_adv) begin
            if (win_idx == 3'(NUM_REQ - 1)) begin
              rr_ptr_d = PTR_BASE;
            end else begin
              rr_ptr_d = PTR_W'(win_idx) + PTR_W'(1);
            end
          end
          // Hard walls only change during a maze load.
          if (sel_we) begin
            mem_we    = sel_in_range && (sel_cur != 2'd1);
            mem_row   = sel_row;
            mem_col   = sel_col;
            mem_wdata = sel_wdata;
          end else begin
            rvalid_d   = 1'b1;
            rdata_d    = sel_cur;
            rdata_id_d = win_idx;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN && mem_we) begin
      map_q[mem_row][mem_col] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= ST_INIT;
      init_row_q <= '0;
      init_col_q <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rdata_id_q <= '0;
      busy_q     <= 1'b1;
      rd_code_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_row_q <= init_row_d;
      init_col_q <= init_col_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rdata_id_q <= rdata_id_d;
      busy_q     <= busy_d;
      rd_code_q  <= rd_code_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rdata_id = rdata_id_q;
  assign busy     = busy_q;
  assign rd_code  = rd_code_q;

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// Directed self-checking bench for maze_tile_arbiter (3 requesters, 13x19 map).
// Expected grant orders follow MAZE_ARB_PRIO0_EN when the bench is built with it.
module tb_maze_tile_arbiter;

  logic        clk;
  logic        resetN;
  logic        init_req;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [11:0] req_row;
  logic [14:0] req_col;
  logic [5:0]  req_wdata;
  logic [2:0]  gnt;
  logic        rvalid;
  logic [1:0]  rdata;
  logic [2:0]  rdata_id;
  logic        busy;
  logic [3:0]  rd_row;
  logic [4:0]  rd_col;
  logic [1:0]  rd_code;

  int compared;
  int mismatched;

  maze_tile_arbiter #(.NUM_REQ(3), .ROWS(13), .COLS(19)) dut (
    .clk(clk), .resetN(resetN), .init_req(init_req),
    .req(req), .we(we), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rdata_id(rdata_id), .busy(busy),
    .rd_row(rd_row), .rd_col(rd_col), .rd_code(rd_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access from requester id starting at a negedge; returns what was seen with gnt.
  task automatic do_access(input int id, input logic w, input logic [3:0] row,
                           input logic [4:0] col, input logic [1:0] wd,
                           output logic got, output logic rv, output logic [1:0] rd,
                           output logic [2:0] rid);
    int n;
    got = 1'b0; rv = 1'b0; rd = 2'd0; rid = 3'd0;
    req = '0; we = '0;
    req_row[4*id +: 4]   = row;
    req_col[5*id +: 5]   = col;
    req_wdata[2*id +: 2] = wd;
    we[id]  = w;
    req[id] = 1'b1;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (gnt[id] === 1'b1) begin
        got = 1'b1; rv = rvalid; rd = rdata; rid = rdata_id;
      end
    end
    req = '0; we = '0;
  endtask

  task automatic wait_load(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, gnt, rvalid, rdata, rdata_id, rd_code} !== {1'b1, 3'b000, 1'b0, 2'd0, 3'd0, 2'd0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got busy=%b gnt=%b rvalid=%b rdata=%0d id=%0d rd_code=%0d expected 1 000 0 0 0 0",
               busy, gnt, rvalid, rdata, rdata_id, rd_code);
    end
    resetN = 1'b1;
    wait_load(n);
    compared++;
    if (n !== 247) begin
      mismatched++;
      $display("[TB] FAIL load_length: got %0d cycles expected 247", n);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_gnt [4];
    logic [2:0] exp_id  [4];
`ifdef MAZE_ARB_PRIO0_EN
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_id  = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_id  = '{3'd0, 3'd1, 3'd2, 3'd0};
`endif
    req_row = {4'd1, 4'd1, 4'd1};
    req_col = {5'd1, 5'd1, 5'd1};
    we  = 3'b000;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if ({gnt, rdata_id, rvalid, rdata} !== {exp_gnt[k], exp_id[k], 1'b1, 2'd1}) begin
        mismatched++;
        $display("[TB] FAIL rr_step%0d: got gnt=%b id=%0d rvalid=%b rdata=%0d expected gnt=%b id=%0d rvalid=1 rdata=1",
                 k, gnt, rdata_id, rvalid, rdata, exp_gnt[k], exp_id[k]);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_init_pattern;
    logic got, rv; logic [1:0] rd; logic [2:0] rid;
    logic [3:0] rows [3] = '{4'd1, 4'd0, 4'd12};
    logic [4:0] cols [3] = '{5'd1, 5'd0, 5'd18};
    logic [1:0] exps [3] = '{2'd1, 2'd0, 2'd0};
    for (int k = 0; k < 3; k++) begin
      do_access(0, 1'b0, rows[k], cols[k], 2'd0, got, rv, rd, rid);
      compared++;
      if ({got, rv, rd, rid} !== {1'b1, 1'b1, exps[k], 3'd0}) begin
        mismatched++;
        $display("[TB] FAIL init_read(%0d,%0d): got gnt=%b rvalid=%b rdata=%0d id=%0d expected 1 1 %0d 0",
                 rows[k], cols[k], got, rv, rd, rid, exps[k]);
      end
    end
  endtask

  task automatic test_write_read;
    logic got, rv; logic [1:0] rd; logic [2:0] rid;
    do_access(1, 1'b1, 4'd2, 5'd4, 2'd2, got, rv, rd, rid);
    compared++;
    if ({got, rv} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL write_grant: got gnt=%b rvalid=%b expected gnt=1 rvalid=0", got, rv);
    end
    do_access(0, 1'b0, 4'd2, 5'd4, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rv, rd, rid} !== {1'b1, 1'b1, 2'd2, 3'd0}) begin
      mismatched++;
      $display("[TB] FAIL readback_2_4: got gnt=%b rvalid=%b rdata=%0d id=%0d expected 1 1 2 0", got, rv, rd, rid);
    end
    do_access(2, 1'b1, 4'd0, 5'd2, 2'd3, got, rv, rd, rid);
    do_access(2, 1'b0, 4'd0, 5'd2, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rd, rid} !== {1'b1, 2'd3, 3'd2}) begin
      mismatched++;
      $display("[TB] FAIL readback_0_2: got gnt=%b rdata=%0d id=%0d expected 1 3 2", got, rd, rid);
    end
    rd_row = 4'd2; rd_col = 5'd4;
    @(negedge clk);
    compared++;
    if (rd_code !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL drawer_2_4: got %0d expected 2", rd_code);
    end
    rd_row = 4'd13; rd_col = 5'd0;
    @(negedge clk);
    compared++;
    if (rd_code !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL drawer_oob: got %0d expected 0", rd_code);
    end
  endtask

  task automatic test_dropped_writes;
    logic got, rv; logic [1:0] rd; logic [2:0] rid;
    do_access(2, 1'b1, 4'd1, 5'd1, 2'd0, got, rv, rd, rid);
    do_access(0, 1'b0, 4'd1, 5'd1, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rd} !== {1'b1, 2'd1}) begin
      mismatched++;
      $display("[TB] FAIL wall_immutable: got gnt=%b rdata=%0d expected 1 1", got, rd);
    end
    do_access(1, 1'b0, 4'd13, 5'd0, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rv, rd, rid} !== {1'b1, 1'b1, 2'd1, 3'd1}) begin
      mismatched++;
      $display("[TB] FAIL oob_row: got gnt=%b rvalid=%b rdata=%0d id=%0d expected 1 1 1 1", got, rv, rd, rid);
    end
    do_access(0, 1'b0, 4'd0, 5'd19, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rd} !== {1'b1, 2'd1}) begin
      mismatched++;
      $display("[TB] FAIL oob_col: got gnt=%b rdata=%0d expected 1 1", got, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_a, exp_b;
`ifdef MAZE_ARB_PRIO0_EN
    exp_a = 3'b001; exp_b = 3'b001;
`else
    exp_a = 3'b010; exp_b = 3'b001;
`endif
    req_row = {4'd0, 4'd0, 4'd0};
    req_col = {5'd0, 5'd0, 5'd0};
    we  = 3'b000;
    req = 3'b001;
    @(negedge clk);
    compared++;
    if (gnt !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got gnt=%b expected 001", gnt);
    end
    req = 3'b011;
    @(negedge clk);
    compared++;
    if (gnt !== exp_a) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got gnt=%b expected %b", gnt, exp_a);
    end
    @(negedge clk);
    compared++;
    if (gnt !== exp_b) begin
      mismatched++;
      $display("[TB] FAIL b2b_third: got gnt=%b expected %b", gnt, exp_b);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_init_req_priority;
    logic got, rv; logic [1:0] rd; logic [2:0] rid;
    int n;
    int gnt_in_load;
    req_row = {4'd2, 4'd2, 4'd2};
    req_col = {5'd4, 5'd4, 5'd4};
    we = 3'b000;
    req = 3'b011;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    compared++;
    if ({gnt, busy} !== {3'b000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL init_req_prio: got gnt=%b busy=%b expected 000 1", gnt, busy);
    end
    req = 3'b001;
    n = 0;
    gnt_in_load = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (gnt !== 3'b000) gnt_in_load++;
    end
    req = '0;
    compared++;
    if ({n, gnt_in_load} !== {32'd247, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL reload: got %0d cycles with %0d grants expected 247 cycles 0 grants", n, gnt_in_load);
    end
    do_access(1, 1'b0, 4'd2, 5'd4, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rd} !== {1'b1, 2'd0}) begin
      mismatched++;
      $display("[TB] FAIL restored_2_4: got gnt=%b rdata=%0d expected 1 0", got, rd);
    end
  endtask

  task automatic test_reset_mid_init;
    logic got, rv; logic [1:0] rd; logic [2:0] rid;
    int n;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (100) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_init_busy: got %b expected 1", busy);
    end
    resetN = 1'b1;
    wait_load(n);
    compared++;
    if (n !== 247) begin
      mismatched++;
      $display("[TB] FAIL mid_init_restart: got %0d cycles expected 247", n);
    end
    do_access(2, 1'b0, 4'd11, 5'd17, 2'd0, got, rv, rd, rid);
    compared++;
    if ({got, rd, rid} !== {1'b1, 2'd1, 3'd2}) begin
      mismatched++;
      $display("[TB] FAIL post_reload_11_17: got gnt=%b rdata=%0d id=%0d expected 1 1 2", got, rd, rid);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetN    = 1'b0;
    init_req  = 1'b0;
    req       = '0;
    we        = '0;
    req_row   = '0;
    req_col   = '0;
    req_wdata = '0;
    rd_row    = '0;
    rd_col    = '0;
    test_reset();
    test_round_robin();
    test_init_pattern();
    test_write_read();
    test_dropped_writes();
    test_back_to_back();
    test_init_req_priority();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
